// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
// SHIFT_SEQ_SRL_EN adds logical right shift (see shift_sequencer.sv).
package shift_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } shift_seq_state_t;

   localparam int STEP_MAX_DEFAULT = 7;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic o;
   } shift_seq_flags_t;

endpackage

// File: rtl/shift_seq_step.sv
// Single-cycle barrel step of 0..7 bits, reporting the last bit shifted out and the OR of all out bits.
// Right shift is only built when SHIFT_SEQ_SRL_EN is defined.
module ShiftSeqStepUnused;
endmodule

module shift_seq_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       step,
   input  logic             dir,
   output logic [WIDTH-1:0] shifted,
   output logic             lastOut,
   output logic             orOut
);

   int stepInt;

   // Bit i of the step (1-based) leaves from the top for a left shift and from the bottom for a right shift.
   always_comb begin
      stepInt = int'(step);
      shifted = data << step;
      lastOut = 1'b0;
      orOut   = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         if (i <= stepInt) begin
            orOut = orOut | data[WIDTH-i];
            if (i == stepInt) lastOut = data[WIDTH-i];
         end
      end
`ifdef SHIFT_SEQ_SRL_EN
      if (dir) begin
         shifted = data >> step;
         lastOut = 1'b0;
         orOut   = 1'b0;
         for (int i = 1; i <= 7; i++) begin
            if (i <= stepInt) begin
               orOut = orOut | data[i-1];
               if (i == stepInt) lastOut = data[i-1];
            end
         end
      end
`endif
   end

`ifndef SHIFT_SEQ_SRL_EN
   logic unusedDir;
   assign unusedDir = dir;
`endif

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle full-range logical shifter: splits the amount into steps of at most STEP_MAX bits.
// Define SHIFT_SEQ_SRL_EN to make in_dir = 1 select a zero-filling right shift.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int AMT_W    = 5,
   parameter int STEP_MAX = STEP_MAX_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_z,
   output logic             out_n,
   output logic             out_c,
   output logic             out_o
);

   shift_seq_state_t state;
   shift_seq_flags_t flagsQ;
   logic [WIDTH-1:0] dataQ;
   logic [WIDTH-1:0] outData;
   logic [AMT_W-1:0] remQ;
   logic [AMT_W-1:0] remNext;
   logic [2:0]       stepAmt;
   logic             cAcc;
   logic             oAcc;
   logic             stepDir;
   logic [WIDTH-1:0] shifted;
   logic             lastOut;
   logic             orOut;

`ifdef SHIFT_SEQ_SRL_EN
   logic dirQ;
   assign stepDir = dirQ;
`else
   logic unusedInDir;
   assign unusedInDir = in_dir;
   assign stepDir     = 1'b0;
`endif

   // Each cycle takes as much of the remaining amount as the barrel step allows.
   always_comb begin
      if (remQ > AMT_W'(STEP_MAX)) stepAmt = 3'(STEP_MAX);
      else                         stepAmt = remQ[2:0];
      remNext = remQ - AMT_W'(stepAmt);
   end

   shift_seq_step #(.WIDTH(WIDTH)) stepUnit (
      .data    (dataQ),
      .step    (stepAmt),
      .dir     (stepDir),
      .shifted (shifted),
      .lastOut (lastOut),
      .orOut   (orOut)
   );

   // Control FSM plus datapath registers; result registers only load on entry to DONE so a flush never leaks a partial result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         dataQ   <= '0;
         remQ    <= '0;
         cAcc    <= 1'b0;
         oAcc    <= 1'b0;
         outData <= '0;
         flagsQ  <= '0;
`ifdef SHIFT_SEQ_SRL_EN
         dirQ    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!flush && in_valid) begin
                  dataQ <= in_data;
                  remQ  <= in_amt;
                  cAcc  <= 1'b0;
                  oAcc  <= 1'b0;
`ifdef SHIFT_SEQ_SRL_EN
                  dirQ  <= in_dir;
`endif
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  dataQ <= shifted;
                  remQ  <= remNext;
                  if (stepAmt != 3'd0) begin
                     cAcc <= lastOut;
                     oAcc <= oAcc | orOut;
                  end
                  if (remNext == '0) begin
                     state    <= DONE;
                     outData  <= shifted;
                     flagsQ.z <= (shifted == '0);
                     flagsQ.n <= shifted[WIDTH-1];
                     flagsQ.c <= (stepAmt != 3'd0) ? lastOut : cAcc;
                     flagsQ.o <= oAcc | orOut;
                  end
               end
            end
            DONE: begin
               if (flush || out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = outData;
   assign out_z     = flagsQ.z;
   assign out_n     = flagsQ.n;
   assign out_c     = flagsQ.c;
   assign out_o     = flagsQ.o;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed spec vectors plus randomized operations against a wide-shift model.
// Expectations follow SHIFT_SEQ_SRL_EN when it is defined for the build.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        in_dir;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_z, out_n, out_c, out_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] expData;
   logic [3:0]  expFlags;
   int          expSteps;
   logic [31:0] lastData;

   shift_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_dir    (in_dir),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_z     (out_z),
      .out_n     (out_n),
      .out_c     (out_c),
      .out_o     (out_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: shift through a 64-bit window; the bits that fall off land in the other half.
   task automatic setExpect(input logic [31:0] data, input logic [4:0] amt, input logic dir);
      logic [63:0] wide;
      logic [31:0] lost;
      logic        lastBit;
      logic        useRight;
`ifdef SHIFT_SEQ_SRL_EN
      useRight = dir;
`else
      useRight = 1'b0;
`endif
      if (useRight) begin
         wide    = {data, 32'h0} >> amt;
         expData = wide[63:32];
         lost    = wide[31:0];
         lastBit = wide[31];
      end else begin
         wide    = {32'h0, data} << amt;
         expData = wide[31:0];
         lost    = wide[63:32];
         lastBit = wide[32];
      end
      expFlags = {(expData == 32'h0), expData[31], lastBit, (lost != 32'h0)};
      expSteps = (amt == 5'd0) ? 1 : (int'(amt) + 6) / 7;
   endtask

   task automatic startOp(input logic [31:0] data, input logic [4:0] amt, input logic dir);
      setExpect(data, amt, dir);
      in_valid = 1'b1;
      in_data  = data;
      in_amt   = amt;
      in_dir   = dir;
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      in_amt   = 5'($urandom);
      in_dir   = 1'($urandom);
   endtask

   task automatic finishOp(input string tag, input int hold);
      int cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      checkOutput($sformatf("%s latency", tag), cyc, expSteps);
      checkOutput($sformatf("%s data", tag), out_data, expData);
      checkOutput($sformatf("%s flags zncо", tag), {28'h0, out_z, out_n, out_c, out_o}, {28'h0, expFlags});
      for (int h = 0; h < hold; h++) begin
         tick();
         checkOutput($sformatf("%s hold data", tag), out_data, expData);
         checkOutput($sformatf("%s hold vr", tag), {30'h0, out_valid, in_ready}, 32'h2);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput($sformatf("%s pop vr", tag), {30'h0, out_valid, in_ready}, 32'h1);
      lastData = expData;
   endtask

   task automatic applyStimulus(input string tag, input logic [31:0] data, input logic [4:0] amt, input logic dir, input int hold);
      checkOutput($sformatf("%s ready", tag), {31'h0, in_ready}, 32'h1);
      startOp(data, amt, dir);
      finishOp(tag, hold);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_dir    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      lastData  = 32'h0;
      #12;
      checkOutput("reset vr", {30'h0, out_valid, in_ready}, 32'h1);
      checkOutput("reset data", out_data, 32'h0);
      checkOutput("reset flags", {28'h0, out_z, out_n, out_c, out_o}, 32'h0);
      rst = 1'b0;
      tick();

      applyStimulus("t1 amt1", 32'h8000_0001, 5'd1, 1'b0, 0);
      checkOutput("t1 const", lastData, 32'h0000_0002);
      applyStimulus("t2 amt31", 32'h0000_0001, 5'd31, 1'b0, 0);
      checkOutput("t2 const", lastData, 32'h8000_0000);
      applyStimulus("t3 amt0", 32'hFFFF_FFFF, 5'd0, 1'b0, 0);
      applyStimulus("t3 amt14", 32'hFFFF_FFFF, 5'd14, 1'b0, 0);
      checkOutput("t3 const", lastData, 32'hFFFF_C000);

      // Held result with a second request waiting; it must only be taken the cycle after the pop.
      startOp(32'h1234_5678, 5'd9, 1'b0);
      finishOp("t4a", 4);
      checkOutput("t4 idle after pop", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b1;
      in_data  = 32'h0F0F_0F0F;
      in_amt   = 5'd17;
      in_dir   = 1'b0;
      setExpect(32'h0F0F_0F0F, 5'd17, 1'b0);
      tick();
      in_valid = 1'b0;
      checkOutput("t4 accepted", {31'h0, in_ready}, 32'h0);
      finishOp("t4b", 0);

      // Flush on the second step of a 3-step operation.
      startOp(32'hDEAD_BEEF, 5'd20, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("t5 flush vr", {30'h0, out_valid, in_ready}, 32'h1);
      checkOutput("t5 flush data kept", out_data, lastData);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("t5 no valid", {31'h0, out_valid}, 32'h0);
      end

      // Flush while idle blocks acceptance.
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checkOutput("t5 idle flush", {31'h0, in_ready}, 32'h1);

      // Asynchronous reset in the middle of a shift.
      startOp(32'h0000_0001, 5'd31, 1'b0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5 rst vr", {30'h0, out_valid, in_ready}, 32'h1);
      checkOutput("t5 rst data", out_data, 32'h0);
      checkOutput("t5 rst flags", {28'h0, out_z, out_n, out_c, out_o}, 32'h0);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("t5 post rst", {30'h0, out_valid, in_ready}, 32'h1);
      end

      applyStimulus("t6 dir1", 32'h0000_0081, 5'd8, 1'b1, 0);
`ifdef SHIFT_SEQ_SRL_EN
      checkOutput("t6 const", lastData, 32'h0000_0000);
`else
      checkOutput("t6 const", lastData, 32'h0000_8100);
`endif

      for (int k = 0; k < 24; k++) begin
         applyStimulus($sformatf("rand%0d", k), $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
